// File: rtl/sync_coord_tracker.sv
// Recovers frame-aligned raster coordinates (vcnt/hcnt) from level hsync/vsync,
// locking with a SEARCH/ACQUIRE/LOCKED FSM and counting timing mismatches.
module sync_coord_tracker #(
  parameter int FRAME_HEIGHT = 525,
  parameter int FRAME_WIDTH  = 800,
  parameter int ERR_BITW     = 8,
  localparam int V_BITW      = $clog2(FRAME_HEIGHT),
  localparam int H_BITW      = $clog2(FRAME_WIDTH)
) (
  input  logic                clock,
  input  logic                n_rst,
  input  logic                in_vsync,
  input  logic                in_hsync,
  output logic [V_BITW-1:0]   out_vcnt,
  output logic [H_BITW-1:0]   out_hcnt,
  output logic                out_locked,
  output logic                out_err,
  output logic [ERR_BITW-1:0] err_count,
  output logic [1:0]          out_dbg_state
);

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  localparam logic [H_BITW-1:0]   H_LAST  = H_BITW'(FRAME_WIDTH - 1);
  localparam logic [V_BITW-1:0]   V_LAST  = V_BITW'(FRAME_HEIGHT - 1);
  localparam logic [ERR_BITW-1:0] ERR_MAX = '1;

  state_t              r_state;
  logic                r_prev_h;
  logic                r_prev_v;
  logic [V_BITW-1:0]   r_v;
  logic [H_BITW-1:0]   r_h;
  logic [V_BITW-1:0]   r_vcnt;
  logic [H_BITW-1:0]   r_hcnt;
  logic                r_locked;
  logic                r_err;
  logic [ERR_BITW-1:0] r_err_count;

  logic              w_hrise;
  logic              w_vrise;
  logic [V_BITW-1:0] w_pv;
  logic [H_BITW-1:0] w_ph;
  logic              w_origin;
  logic              w_h_mis;
  logic              w_v_mis;
  logic [V_BITW-1:0] w_next_v;
  logic [H_BITW-1:0] w_next_h;

  always_comb begin
    w_hrise = in_hsync & ~r_prev_h;
    w_vrise = in_vsync & ~r_prev_v;
    w_ph    = (r_h == H_LAST) ? '0 : r_h + 1'b1;
    w_pv    = r_v;
    if (r_h == H_LAST) begin
      w_pv = (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end
    w_origin = (w_pv == '0) && (w_ph == '0);
    // A line start must coincide exactly with an hsync rising edge.
    w_h_mis  = w_hrise ^ (w_ph == '0);
    w_v_mis  = w_vrise & ~w_origin;
    // Any vsync rise outside SEARCH redefines the current sample as (0,0).
    w_next_v = w_vrise ? '0 : w_pv;
    w_next_h = w_vrise ? '0 : w_ph;
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ST_SEARCH;
      r_prev_h    <= 1'b1;
      r_prev_v    <= 1'b1;
      r_v         <= '0;
      r_h         <= '0;
      r_vcnt      <= '0;
      r_hcnt      <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_prev_h <= in_hsync;
      r_prev_v <= in_vsync;
      r_err    <= 1'b0;
      case (r_state)
        ST_SEARCH: begin
          r_locked <= 1'b0;
          if (w_vrise) begin
            r_state <= ST_ACQUIRE;
            r_v     <= '0;
            r_h     <= '0;
            r_vcnt  <= '0;
            r_hcnt  <= '0;
          end
        end
        ST_ACQUIRE: begin
          r_v    <= w_next_v;
          r_h    <= w_next_h;
          r_vcnt <= w_next_v;
          r_hcnt <= w_next_h;
          if (w_vrise) begin
            if (w_origin && !w_h_mis) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_state  <= ST_ACQUIRE;
              r_locked <= 1'b0;
            end
          end else if (w_h_mis) begin
            r_state  <= ST_SEARCH;
            r_locked <= 1'b0;
          end else begin
            r_locked <= 1'b0;
          end
        end
        ST_LOCKED: begin
          r_v    <= w_next_v;
          r_h    <= w_next_h;
          r_vcnt <= w_next_v;
          r_hcnt <= w_next_h;
          if (w_h_mis || w_v_mis) begin
            r_err    <= 1'b1;
            r_locked <= 1'b0;
            if (r_err_count != ERR_MAX) begin
              r_err_count <= r_err_count + 1'b1;
            end
            r_state <= w_vrise ? ST_ACQUIRE : ST_SEARCH;
          end else begin
            r_locked <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_SEARCH;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign out_vcnt      = r_vcnt;
  assign out_hcnt      = r_hcnt;
  assign out_locked    = r_locked;
  assign out_err       = r_err;
  assign err_count     = r_err_count;
  assign out_dbg_state = r_state;

endmodule

// File: tb/tb_sync_coord_tracker.sv
// Directed bench for sync_coord_tracker on an 8x4 raster: the driver pushes the
// hand-derived response of each sample, a monitor pops and compares it one cycle later.
module tb_sync_coord_tracker;

  localparam int EXP_W = 18;
  localparam logic [1:0] SR = 2'd0;
  localparam logic [1:0] AQ = 2'd1;
  localparam logic [1:0] LK = 2'd2;

  logic       clock;
  logic       n_rst;
  logic       in_vsync;
  logic       in_hsync;
  logic [1:0] out_vcnt;
  logic [2:0] out_hcnt;
  logic       out_locked;
  logic       out_err;
  logic [7:0] err_count;
  logic [1:0] out_dbg_state;

  int total = 0;
  int bad   = 0;
  int n_mon = 0;

  // {chk_coord, locked, err, state[1:0], err_count[7:0], vcnt[1:0], hcnt[2:0]}
  logic [EXP_W-1:0] exp_q[$];

  sync_coord_tracker #(
    .FRAME_HEIGHT(4),
    .FRAME_WIDTH (8),
    .ERR_BITW    (8)
  ) dut (
    .clock        (clock),
    .n_rst        (n_rst),
    .in_vsync     (in_vsync),
    .in_hsync     (in_hsync),
    .out_vcnt     (out_vcnt),
    .out_hcnt     (out_hcnt),
    .out_locked   (out_locked),
    .out_err      (out_err),
    .err_count    (err_count),
    .out_dbg_state(out_dbg_state)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Monitor: one registered response per driven sample.
  always @(posedge clock) begin
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {e[17], out_locked, out_err, out_dbg_state, err_count,
           e[17] ? out_vcnt : 2'd0, e[17] ? out_hcnt : 3'd0};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL sample%0d: got lk=%b err=%b st=%0d cnt=%0d v=%0d h=%0d, want lk=%b err=%b st=%0d cnt=%0d v=%0d h=%0d",
                 n_mon, a[16], a[15], a[14:13], a[12:5], a[4:3], a[2:0],
                 e[16], e[15], e[14:13], e[12:5], e[4:3], e[2:0]);
      end
      n_mon++;
    end
  end

  task automatic drive(input logic hs, input logic vs, input logic lk, input logic er,
                       input logic [1:0] st, input logic [7:0] cnt, input logic chk,
                       input int v, input int h);
    logic [1:0] ev;
    logic [2:0] eh;
    ev = chk ? 2'(v) : 2'd0;
    eh = chk ? 3'(h) : 3'd0;
    @(negedge clock);
    in_hsync = hs;
    in_vsync = vs;
    exp_q.push_back({chk, lk, er, st, cnt, ev, eh});
  endtask

  // Regular stream: hsync high on h=0..1, vsync high on lines 0..1.
  task automatic run_frame(input int v0, input int h0, input int n, input logic [1:0] st,
                           input logic lk, input logic [7:0] cnt, input logic chk);
    int v;
    int h;
    v = v0;
    h = h0;
    for (int i = 0; i < n; i++) begin
      drive(h < 2, v < 2, lk, 1'b0, st, cnt, chk, v, h);
      h++;
      if (h == 8) begin
        h = 0;
        v = (v == 3) ? 0 : v + 1;
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if ({out_locked, out_err, out_dbg_state, err_count, out_vcnt, out_hcnt} !== 17'd0) begin
      bad++;
      $display("FAIL %s: got lk=%b err=%b st=%0d cnt=%0d v=%0d h=%0d, want all zero",
               name, out_locked, out_err, out_dbg_state, err_count, out_vcnt, out_hcnt);
    end
  endtask

  initial begin
    int c;
    n_rst    = 1'b0;
    in_vsync = 1'b0;
    in_hsync = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clock);
    n_rst = 1'b1;

    // Mid-frame start: first vrise acquires, second locks.
    run_frame(2, 3, 13, SR, 1'b0, 8'd0, 1'b0);
    run_frame(0, 0, 32, AQ, 1'b0, 8'd0, 1'b1);
    run_frame(0, 0, 32, LK, 1'b1, 8'd0, 1'b1);

    // hsync pulse moved early to (1,6): hrise off the line start.
    run_frame(0, 0, 14, LK, 1'b1, 8'd0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, SR, 8'd1, 1'b0, 1, 6);
    drive(1'b1, 1'b1, 1'b0, 1'b0, SR, 8'd1, 1'b0, 1, 7);
    for (int h = 0; h < 8; h++) drive(1'b0, 1'b0, 1'b0, 1'b0, SR, 8'd1, 1'b0, 2, h);
    run_frame(3, 0, 8, SR, 1'b0, 8'd1, 1'b0);
    run_frame(0, 0, 32, AQ, 1'b0, 8'd1, 1'b1);
    run_frame(0, 0, 32, LK, 1'b1, 8'd1, 1'b1);

    // vsync drops during line 1 and rises at line 2: restart acquire there.
    run_frame(0, 0, 8, LK, 1'b1, 8'd1, 1'b1);
    for (int h = 0; h < 8; h++) drive(h < 2, 1'b0, 1'b1, 1'b0, LK, 8'd1, 1'b1, 1, h);
    drive(1'b1, 1'b1, 1'b0, 1'b1, AQ, 8'd2, 1'b1, 0, 0);
    run_frame(0, 1, 31, AQ, 1'b0, 8'd2, 1'b1);
    run_frame(0, 0, 32, LK, 1'b1, 8'd2, 1'b1);

    // hsync missing for line 2: error where the line should start.
    run_frame(0, 0, 16, LK, 1'b1, 8'd2, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, SR, 8'd3, 1'b0, 2, 0);
    for (int h = 1; h < 8; h++) drive(1'b0, 1'b0, 1'b0, 1'b0, SR, 8'd3, 1'b0, 2, h);
    run_frame(3, 0, 8, SR, 1'b0, 8'd3, 1'b0);
    run_frame(0, 0, 32, AQ, 1'b0, 8'd3, 1'b1);
    run_frame(0, 0, 32, LK, 1'b1, 8'd3, 1'b1);

    // 300 forced mismatches: early vrise at (1,0), reacquire, relock, repeat.
    c = 3;
    for (int it = 0; it < 300; it++) begin
      for (int h = 0; h < 8; h++) drive(h < 2, h < 4, 1'b1, 1'b0, LK, 8'(c), 1'b1, 0, h);
      c = (c < 255) ? c + 1 : 255;
      drive(1'b1, 1'b1, 1'b0, 1'b1, AQ, 8'(c), 1'b1, 0, 0);
      run_frame(0, 1, 31, AQ, 1'b0, 8'(c), 1'b1);
    end
    run_frame(0, 0, 32, LK, 1'b1, 8'd255, 1'b1);

    // Asynchronous reset while locked, with both syncs held high through release.
    run_frame(0, 0, 10, LK, 1'b1, 8'd255, 1'b1);
    @(posedge clock);
    #3;
    n_rst    = 1'b0;
    in_vsync = 1'b1;
    in_hsync = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, SR, 8'd0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, SR, 8'd0, 1'b0, 0, 0);
    run_frame(0, 0, 32, AQ, 1'b0, 8'd0, 1'b1);
    run_frame(0, 0, 32, LK, 1'b1, 8'd0, 1'b1);

    repeat (3) @(posedge clock);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending responses, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
